// File: rtl/fc_pkg.sv
// fc_pkg: shared sizes, derived widths and FSM encoding for the fully-connected sequencer.
package fc_pkg;

    localparam int IN_SIZE    = 75;
    localparam int OUT_SIZE   = 10;
    localparam int DATA_WIDTH = 16;
    localparam int CLASS_W    = 4;

    localparam int W_LEN      = IN_SIZE * OUT_SIZE;
    localparam int MAP_AW     = $clog2(IN_SIZE);
    localparam int W_AW       = $clog2(W_LEN);
    localparam int BIAS_AW    = CLASS_W;
    localparam int STREAM_LEN = IN_SIZE + W_LEN + OUT_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RD_MAP = 3'd2,
        ST_RD_W   = 3'd3,
        ST_RD_B   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_WAIT   = 3'd6,
        ST_DONE   = 3'd7
    } fc_state_e;

endpackage

// File: rtl/fc_seq_ctrl_if.sv
// fc_seq_ctrl_if: control, memory-port and fc_layer signals of the sequencer; master is the sequencer side.
interface fc_seq_ctrl_if;
    import fc_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [CLASS_W-1:0]    class_out;
    logic [DATA_WIDTH-1:0] max_score;

    logic                  map_rd_en;
    logic [MAP_AW-1:0]     map_addr;
    logic [DATA_WIDTH-1:0] map_rdata;
    logic                  weight_rd_en;
    logic [W_AW-1:0]       weight_addr;
    logic [DATA_WIDTH-1:0] weight_rdata;
    logic                  bias_rd_en;
    logic [BIAS_AW-1:0]    bias_addr;
    logic [DATA_WIDTH-1:0] bias_rdata;

    logic                  start_fc;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] map_in_serial;
    logic [DATA_WIDTH-1:0] weight_serial;
    logic [DATA_WIDTH-1:0] bias_serial;
    logic                  finish_fc;
    logic [DATA_WIDTH-1:0] predict_out;
    logic                  predict_out_valid;

    modport master (
        input  start, map_rdata, weight_rdata, bias_rdata,
               finish_fc, predict_out, predict_out_valid,
        output busy, done, error, class_out, max_score,
               map_rd_en, map_addr, weight_rd_en, weight_addr, bias_rd_en, bias_addr,
               start_fc, data_valid, map_in_serial, weight_serial, bias_serial
    );

    modport slave (
        output start, map_rdata, weight_rdata, bias_rdata,
               finish_fc, predict_out, predict_out_valid,
        input  busy, done, error, class_out, max_score,
               map_rd_en, map_addr, weight_rd_en, weight_addr, bias_rd_en, bias_addr,
               start_fc, data_valid, map_in_serial, weight_serial, bias_serial
    );
endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: streaming signed max tracker; ties keep the lowest index, samples past OUT_SIZE are ignored.
module fc_argmax
    import fc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic        [CLASS_W-1:0]    idx_o,
    output logic signed [DATA_WIDTH-1:0] max_o
);
    localparam int CNT_W = $clog2(OUT_SIZE + 1);

    logic        [CNT_W-1:0]      cnt_q, cnt_d;
    logic        [CLASS_W-1:0]    idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic                         accept_s, take_s;

    // Outputs already include the current sample so a same-edge capture sees it
    always_comb begin
        accept_s = valid_i && (cnt_q < CNT_W'(OUT_SIZE));
        take_s   = accept_s && ((cnt_q == '0) || (data_i > max_q));
        max_d    = take_s ? data_i : max_q;
        idx_d    = take_s ? CLASS_W'(cnt_q) : idx_q;
        cnt_d    = accept_s ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // Running max / index / sample-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            max_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
            idx_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            max_q <= max_d;
        end
    end

    assign idx_o = idx_d;
    assign max_o = max_d;
endmodule

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: streams feature map, weights and biases into fc_layer and reports the argmax class.
// Optional WAIT watchdog is enabled by defining FC_SEQ_TIMEOUT_EN.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    fc_seq_ctrl_if.master bus
);
    localparam int CNT_MAX = (W_LEN > TIMEOUT_CYC) ? W_LEN : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    fc_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         timeout_s, acc_en_s;
    logic [CLASS_W-1:0]           am_idx_s;
    logic signed [DATA_WIDTH-1:0] am_max_s;

    logic                  start_fc_q, start_fc_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                  map_rd_en_q, map_rd_en_d, w_rd_en_q, w_rd_en_d, b_rd_en_q, b_rd_en_d;
    logic [MAP_AW-1:0]     map_addr_q, map_addr_d;
    logic [W_AW-1:0]       w_addr_q, w_addr_d;
    logic [BIAS_AW-1:0]    b_addr_q, b_addr_d;
    logic [CLASS_W-1:0]    class_q, class_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  map_ret_q, w_ret_q, b_ret_q;
    logic [DATA_WIDTH-1:0] map_hold_q, w_hold_q, b_hold_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt_q is the read address in read phases and the watchdog in WAIT
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE:   state_d = bus.start ? ST_START : ST_IDLE;
            ST_START:  state_d = ST_RD_MAP;
            ST_RD_MAP: begin
                if (cnt_q == CNT_W'(IN_SIZE - 1)) state_d = ST_RD_W;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RD_W: begin
                if (cnt_q == CNT_W'(W_LEN - 1)) state_d = ST_RD_B;
                else                            cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RD_B: begin
                if (cnt_q == CNT_W'(OUT_SIZE - 1)) state_d = ST_DRAIN;
                else                               cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DRAIN:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.finish_fc) begin
                    state_d = ST_DONE;
                end
`ifdef FC_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_DONE;
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign acc_en_s = state_q inside {ST_RD_MAP, ST_RD_W, ST_RD_B, ST_DRAIN, ST_WAIT};

    fc_argmax u_argmax (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (state_q == ST_START),
        .valid_i (bus.predict_out_valid && acc_en_s),
        .data_i  ($signed(bus.predict_out)),
        .idx_o   (am_idx_s),
        .max_o   (am_max_s)
    );

    // Output decode from the next state so every output leaves a flop aligned with its state
    always_comb begin
        start_fc_d  = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        error_d     = done_d && timeout_s;
        map_rd_en_d = (state_d == ST_RD_MAP);
        w_rd_en_d   = (state_d == ST_RD_W);
        b_rd_en_d   = (state_d == ST_RD_B);
        map_addr_d  = map_rd_en_d ? MAP_AW'(cnt_d) : '0;
        w_addr_d    = w_rd_en_d ? W_AW'(cnt_d) : '0;
        b_addr_d    = b_rd_en_d ? BIAS_AW'(cnt_d) : '0;
        if (done_d && timeout_s) begin
            class_d = '0;
            max_d   = '0;
        end else if (done_d) begin
            class_d = am_idx_s;
            max_d   = am_max_s;
        end else begin
            class_d = class_q;
            max_d   = max_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_fc_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            map_rd_en_q <= 1'b0;
            w_rd_en_q   <= 1'b0;
            b_rd_en_q   <= 1'b0;
            map_addr_q  <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            class_q     <= '0;
            max_q       <= '0;
        end else begin
            start_fc_q  <= start_fc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            map_rd_en_q <= map_rd_en_d;
            w_rd_en_q   <= w_rd_en_d;
            b_rd_en_q   <= b_rd_en_d;
            map_addr_q  <= map_addr_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            class_q     <= class_d;
            max_q       <= max_d;
        end
    end

    // Read-return tracking; each serial bus shows its registered memory word while that phase returns, else holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_ret_q  <= 1'b0;
            w_ret_q    <= 1'b0;
            b_ret_q    <= 1'b0;
            map_hold_q <= '0;
            w_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            map_ret_q  <= map_rd_en_q;
            w_ret_q    <= w_rd_en_q;
            b_ret_q    <= b_rd_en_q;
            map_hold_q <= map_ret_q ? bus.map_rdata : map_hold_q;
            w_hold_q   <= w_ret_q ? bus.weight_rdata : w_hold_q;
            b_hold_q   <= b_ret_q ? bus.bias_rdata : b_hold_q;
        end
    end

    assign bus.start_fc      = start_fc_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.class_out     = class_q;
    assign bus.max_score     = max_q;
    assign bus.map_rd_en     = map_rd_en_q;
    assign bus.map_addr      = map_addr_q;
    assign bus.weight_rd_en  = w_rd_en_q;
    assign bus.weight_addr   = w_addr_q;
    assign bus.bias_rd_en    = b_rd_en_q;
    assign bus.bias_addr     = b_addr_q;
    assign bus.data_valid    = map_ret_q | w_ret_q | b_ret_q;
    assign bus.map_in_serial = map_ret_q ? bus.map_rdata : map_hold_q;
    assign bus.weight_serial = w_ret_q ? bus.weight_rdata : w_hold_q;
    assign bus.bias_serial   = b_ret_q ? bus.bias_rdata : b_hold_q;
endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
- Sequencer for the fully-connected classifier stage.
- Reads feature map, weights and biases from three synchronous-read memories and streams them serially into fc_layer.
- Issues the fc_layer start pulse, collects the OUT_SIZE scores and reports the argmax class with a done pulse.
- Sits between the conv/pool feature buffer plus the parameter ROMs and the top-level result register.

Parameters:
- IN_SIZE, 75, feature-map length per inference.
- OUT_SIZE, 10, number of classes.
- DATA_WIDTH, 16, signed fixed-point word width.
- CLASS_W, 4, class-index width (ceil(log2(OUT_SIZE))).
- TIMEOUT_CYC, 4096, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run one inference; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse: result valid.
- error  out  1  one-cycle pulse with done on watchdog expiry.
- class_out  out  CLASS_W  argmax index, held until next done.
- max_score  out  DATA_WIDTH  signed winning score, held until next done.
- map_rd_en / map_addr / map_rdata  out 1 / out ceil(log2(IN_SIZE)) / in DATA_WIDTH  feature memory port, rdata 1 cycle after rd_en.
- weight_rd_en / weight_addr / weight_rdata  out 1 / out ceil(log2(IN_SIZE*OUT_SIZE)) / in DATA_WIDTH  weight ROM port, rdata 1 cycle after rd_en.
- bias_rd_en / bias_addr / bias_rdata  out 1 / out CLASS_W / in DATA_WIDTH  bias ROM port, rdata 1 cycle after rd_en.
- start_fc  out  1  to fc_layer.
- data_valid  out  1  to fc_layer.
- map_in_serial / weight_serial / bias_serial  out  DATA_WIDTH each  to fc_layer.
- finish_fc  in  1  from fc_layer.
- predict_out  in  DATA_WIDTH  from fc_layer, signed.
- predict_out_valid  in  1  from fc_layer.

Behaviour:
- Reset: all outputs 0, serial buses 0, FSM in IDLE. Reset mid-run aborts with no done.
- FSM states:
  - IDLE -> START on start.
  - START: start_fc=1 for exactly one cycle -> RD_MAP.
  - RD_MAP: addr 0..IN_SIZE-1, one per cycle -> RD_W.
  - RD_W: addr 0..IN_SIZE*OUT_SIZE-1 -> RD_B.
  - RD_B: addr 0..OUT_SIZE-1 -> DRAIN.
  - DRAIN: one cycle for last read return -> WAIT.
  - WAIT: until finish_fc -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Read phases are back-to-back with no bubbles; exactly one rd_en is high per read cycle.
- Serial drive: registered from rdata one cycle after rd_en; data_valid=1 on those cycles only.
  - Only the active phase's bus updates; the others hold their last value.
  - data_valid is continuous for IN_SIZE+IN_SIZE*OUT_SIZE+OUT_SIZE = 835 cycles (defaults).
- Timing: start sampled at edge 0 -> start_fc high cycle 1 -> first rd_en cycle 2 -> first data_valid cycle 3 -> last data_valid cycle 837.
- Argmax:
  - Accumulates on every predict_out_valid, in any state from RD_MAP through WAIT; index counter increments per valid.
  - Signed compare, strictly greater replaces, so ties keep the lowest index.
  - Running max initialised to the first valid sample.
  - Valids beyond OUT_SIZE are ignored.
- finish_fc: finish_fc arriving with fewer than OUT_SIZE valids still completes; the result covers the samples received. finish_fc coincident with the last predict_out_valid includes that sample.
- Output update: class_out/max_score update only in the DONE cycle; busy drops in the DONE cycle.
- start during busy or DONE is dropped. start in IDLE the cycle after DONE is accepted.

Optional Feature:
- Macro FC_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT. Reaching TIMEOUT_CYC without finish_fc -> DONE with error=1, class_out=0, max_score=0.
- Undefined: no counter; error is tied 0; WAIT is unbounded.

Decomposition:
- Shared package fc_pkg:
  - FSM state encoding.
  - DATA_WIDTH, IN_SIZE, OUT_SIZE, CLASS_W defaults.
  - Derived address widths.
  - Total stream length constant.
- One natural sub-module, fc_argmax: a streaming signed max tracker with clear, valid, data, index, max outputs.

Test Plan:
- Nominal run, all scores distinct, class 7 highest (0x0300) -> done once; class_out=7, max_score=0x0300; error=0.
- Stream check: a bench model of fc_layer counts data_valid -> exactly 75/750/10 words, in address order, no gaps, start_fc one cycle, first data_valid 3 cycles after start.
- Tie and negative scores, all scores 0xFF00 except classes 2 and 5 = 0xFFF0 -> class_out=2, max_score=0xFFF0.
- start pulsed again mid-RD_W and in the DONE cycle -> both ignored; one done only. start the cycle after done -> second run starts.
- Reset asserted during RD_W -> all outputs 0 immediately; no done. A new start after release runs normally.
- With FC_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=64 and finish_fc never asserted -> done and error pulse 64 cycles after entering WAIT; class_out=0. Without the macro, error stays 0.
